// File: rtl/irq_dispatch.sv
// Interrupt dispatcher: collects encoded requests into a pending set, offers the highest
// pending id to the CPU, then runs the ack/end-of-interrupt handshake with a withdraw timeout.
module irq_dispatch #(
  parameter int unsigned VEC_W    = 8,
  parameter int unsigned VEC_BASE = 32'h20,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             irq_valid,
  input  logic [2:0]       irq_id,
  input  logic             int_en,
  input  logic             cpu_ack,
  input  logic             cpu_eoi,
  output logic             irq_out,
  output logic [VEC_W-1:0] vector,
  output logic [7:0]       in_service,
  output logic [7:0]       pending,
  output logic             busy,
  output logic [7:0]       drop_cnt
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           state;
  logic [2:0]       sel;
  logic [TMR_W-1:0] timer;

  logic [2:0] top_id;
  logic       grant;
  logic       withdraw;
  logic       drop;
  logic [7:0] set_mask;
  logic [7:0] clr_mask;
  logic [7:0] restore_mask;

  function automatic logic [VEC_W-1:0] vec_of(input logic [2:0] id);
    return VEC_W'(VEC_BASE + 32'(id) * 32'd4);
  endfunction

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    top_id = '0;
    for (int i = 0; i < 8; i++) begin
      if (pending[i]) top_id = 3'(i);
    end
    grant        = (state == IDLE) && int_en && (pending != 8'h00);
    withdraw     = (state == REQ) && !cpu_ack &&
                   ((timer == TMR_W'(TIMEOUT)) || !int_en);
    set_mask     = irq_valid ? (8'b1 << irq_id) : 8'h00;
    clr_mask     = grant ? (8'b1 << top_id) : 8'h00;
    restore_mask = withdraw ? (8'b1 << sel) : 8'h00;
    // A same-edge grant of this id frees the bit, so the new strobe is not a merge.
    drop         = irq_valid && pending[irq_id] && !clr_mask[irq_id];
  end

  // NOTE: state is written only with non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= IDLE;
      sel        <= '0;
      timer      <= '0;
      irq_out    <= 1'b0;
      vector     <= '0;
      in_service <= '0;
      pending    <= '0;
      busy       <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      // Set wins over the grant clear; restore puts a withdrawn request back.
      pending <= (pending & ~clr_mask) | set_mask | restore_mask;
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (grant) begin
            sel     <= top_id;
            vector  <= vec_of(top_id);
            irq_out <= 1'b1;
            timer   <= TMR_W'(1);
            busy    <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (cpu_ack) begin
            irq_out    <= 1'b0;
            in_service <= 8'b1 << sel;
            state      <= SERVICE;
          end else if (withdraw) begin
            irq_out <= 1'b0;
            vector  <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        SERVICE: begin
          if (cpu_eoi) begin
            in_service <= '0;
            vector     <= '0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/irq_dispatch.md
Name: irq_dispatch

Overview:
- Consumer end of the interrupt priority-encoding path. Takes the encoded 3-bit request id plus a valid strobe and accumulates requests in a pending register.
- Arbitrates the pending requests, then runs a request/acknowledge/end-of-interrupt handshake with the CPU core.
- Returns the decoded one-hot in-service mask and a vector address.
- Sits between the priority encoder / status register and the processor's interrupt entry logic.

Parameters:
- VEC_W, 8: width of the vector output.
- VEC_BASE, 8'h20: base address of the vector table. Vector = VEC_BASE + (id * 4), truncated mod 2^VEC_W.
- TIMEOUT, 16: cycles irq_out may stay high without cpu_ack before the request is withdrawn. Must be >= 2.

Ports:
- clk, input, 1: rising-edge clock.
- rstN, input, 1: asynchronous active-low reset.
- irq_valid, input, 1: irq_id is valid this cycle.
- irq_id, input, 3: encoded request id, 7 = highest priority.
- int_en, input, 1: global interrupt enable (status bit 7).
- cpu_ack, input, 1: CPU accepts the current request.
- cpu_eoi, input, 1: CPU signals end of the interrupt service routine.
- irq_out, output, 1: interrupt request to the CPU.
- vector, output, VEC_W: vector address of the request being offered or in service.
- in_service, output, 8: one-hot mask of the id in service; zero otherwise.
- pending, output, 8: pending request bits.
- busy, output, 1: FSM is not in IDLE.
- drop_cnt, output, 8: saturating count of requests merged into an already-pending bit.

Behaviour:
- Reset:
  - rstN low asynchronously forces state IDLE.
  - Clears irq_out, vector, in_service, pending, busy, drop_cnt and the internal sel/timer, all to 0.
  - Reset mid-handshake abandons the request; nothing is retained.
- Request capture (every state):
  - At an edge with irq_valid=1, pending[irq_id] is set.
  - If pending[irq_id] was already 1 and is not being cleared at that same edge, drop_cnt increments, saturating at 255.
  - An id currently in service may be re-pended.
- States: IDLE, REQ, SERVICE.
- IDLE:
  - If int_en=1 and pending != 0: sel = index of the highest set pending bit.
  - At that edge: pending[sel] is cleared, vector = VEC_BASE + 4*sel, irq_out = 1, state goes to REQ.
  - If irq_valid targets sel in that same cycle, pending[sel] ends at 1 and no drop is counted.
- REQ:
  - The timer counts cycles spent in REQ.
  - cpu_ack=1: next state SERVICE, irq_out=0, in_service = 1<<sel.
  - No ack and the timer reaches TIMEOUT, or int_en=0: pending[sel] is restored to 1, irq_out=0, vector=0, next state IDLE.
  - cpu_ack wins over timeout or int_en drop in the same cycle.
- SERVICE:
  - irq_out stays 0 and vector holds.
  - cpu_eoi=1: in_service=0, vector=0, next state IDLE.
  - int_en changes are ignored; service is not preempted (no nesting).
- Ignored inputs: cpu_ack outside REQ, and cpu_eoi outside SERVICE.
- Latency:
  - irq_valid sampled at edge N sets pending at N.
  - irq_out is high after edge N+1, minimum; 2 cycles from strobe to request.
  - From SERVICE exit, the next request can issue one cycle after returning to IDLE.
- busy = (state != IDLE), registered with the state.
- All outputs are registered. There is no combinational path from any input to any output.

Test Plan:
- Reset: assert rstN=0 mid-REQ with pending=8'h81 -> all outputs 0 immediately, without waiting for a clock edge. After release, busy=0.
- Single request: int_en=1, irq_valid with id=5 for one cycle -> irq_out=1 two cycles later, vector=8'h34. Then cpu_ack -> in_service=8'h20, irq_out=0. Then cpu_eoi -> in_service=0, busy=0.
- Priority: ids 2 and 6 pended in the same cycle window with the FSM in IDLE -> id 6 offered first (vector 8'h38), pending=8'h04. After EOI, id 2 offered (vector 8'h28).
- Timeout: id 3 offered, no cpu_ack for 16 cycles -> irq_out drops, pending[3]=1, state IDLE, re-offered next cycle. Ack on the 16th cycle -> goes to SERVICE instead.
- Drop counter: pulse irq_valid id=1 three times while int_en=0 -> pending=8'h02, drop_cnt=2. Drive 300 repeats -> drop_cnt=255.
- Gating and ignores: int_en drop in REQ -> request withdrawn, pending restored. cpu_eoi in IDLE and cpu_ack in SERVICE -> no state change.
